// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program counter and fetch-control stage. Steps prog_ctr
//               sequentially or redirects it to an absolute target on taken
//               jumps, branches, calls and returns. Includes a small
//               call/return stack and a start/run/done handshake that ends
//               when prog_ctr reaches HALT_ADDR.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   begin execution at address 0 (from IDLE or DONE)
//   stall        in   1   hold prog_ctr and all state this cycle
//   jump_en      in   1   unconditional absolute jump to target
//   branch_en    in   1   conditional branch present
//   branch_cond  in   1   branch taken when branch_en && branch_cond
//   call_en      in   1   push prog_ctr+1, jump to target
//   ret_en       in   1   pop return address into prog_ctr
//   target       in   D   absolute target address
//   prog_ctr     out  D   current instruction address
//   busy         out  1   high in RUN
//   done         out  1   high in DONE
//   stack_err    out  1   sticky stack overflow/underflow flag
// ============================================================================
module pc_fetch_ctrl #(
  parameter int D           = 12,
  parameter int HALT_ADDR   = 511,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stall,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic         branch_cond,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         busy,
  output logic         done,
  output logic         stack_err
);

  // Pointer is one bit wider than the entry index so "full" (== depth)
  // is distinguishable from "empty" (== 0).
  localparam int SPW = $clog2(STACK_DEPTH);

  localparam logic [D-1:0] C_HALT = D'(HALT_ADDR);
  localparam logic [SPW:0] C_FULL = (SPW+1)'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [D-1:0]   r_pc;
  logic [D-1:0]   w_pc_nxt;
  logic [D-1:0]   w_pc_inc;
  logic [SPW:0]   r_sp;
  logic [SPW:0]   w_sp_nxt;
  logic [SPW:0]   w_sp_dec;
  logic           r_err;
  logic           w_err_nxt;
  logic           w_push;
  logic           r_busy;
  logic           r_done;
  logic [D-1:0]   r_stack [STACK_DEPTH];

  // Natural D-bit wrap: all-ones + 1 returns to zero, both for stepping and
  // for the return address pushed by a call.
  assign w_pc_inc = r_pc + D'(1);
  assign w_sp_dec = r_sp - (SPW+1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_err_nxt   = r_err;
    w_push      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_pc_nxt = '0;
        if (start) begin
          w_state_nxt = S_RUN;
          w_sp_nxt    = '0;
          w_err_nxt   = 1'b0;
        end
      end

      S_RUN: begin
        if (stall) begin
          // Everything holds, including halt detection.
        end else if (r_pc == C_HALT) begin
          w_state_nxt = S_DONE;
        end else if (ret_en) begin
          if (r_sp != '0) begin
            w_pc_nxt = r_stack[w_sp_dec[SPW-1:0]];
            w_sp_nxt = w_sp_dec;
          end else begin
            w_err_nxt = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        end else if (call_en) begin
          if (r_sp != C_FULL) begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + (SPW+1)'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
          w_pc_nxt = target;
        end else if (jump_en || (branch_en && branch_cond)) begin
          w_pc_nxt = target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end

      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_sp_nxt    = '0;
          w_err_nxt   = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
        w_sp_nxt    = '0;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_sp    <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_err   <= w_err_nxt;
      // Flags follow the next state so they change on the same edge.
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Stack storage needs no reset; the pointer alone defines validity.
  // w_push is only raised in RUN, which reset always leaves.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_sp[SPW-1:0]] <= w_pc_inc;
    end
  end

  assign prog_ctr  = r_pc;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stack_err = r_err;

endmodule
`default_nettype wire
